// File: rtl/fft_pkg.sv
// Shared FFT definitions: complex FP4 sample layout, buffer states and the
// bit-reversal helper used by stage address generators.
package fft_pkg;

  localparam int FP4_W        = 4;
  localparam int CPLX_W       = 8;
  localparam int N_POINTS_DEF = 8;

  localparam int RE_MSB      = 7;
  localparam int RE_LSB      = 4;
  localparam int IM_MSB      = 3;
  localparam int IM_LSB      = 0;
  localparam int FP4_SIGN    = 3;
  localparam int FP4_EXP_MSB = 2;
  localparam int FP4_EXP_LSB = 1;
  localparam int FP4_MANT    = 0;

  localparam int IDX_MAX_W = 8;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } buf_state_e;

  // Reverses the low 'width' bits of idx; bits at or above 'width' must be zero.
  function automatic logic [IDX_MAX_W-1:0] bitrev(input logic [IDX_MAX_W-1:0] idx,
                                                  input int unsigned width);
    logic [IDX_MAX_W-1:0] rev;
    for (int i = 0; i < IDX_MAX_W; i++) begin
      rev[i] = idx[IDX_MAX_W-1-i];
    end
    return rev >> (IDX_MAX_W - width);
  endfunction

endpackage

// File: rtl/fft_frame_ram.sv
// Frame storage: one synchronous write port and two asynchronous read ports,
// kept separate so it can map onto distributed RAM.
module fft_frame_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [DW-1:0] o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] r_mem [DEPTH];

  // Contents are never reset; a frame is always fully rewritten before use.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/fft_bitrev_pair_buffer.sv
// Captures a frame of complex FP4 samples in natural order and replays it as
// bit-reversed (a, b) pairs for the stage-0 butterfly.
module fft_bitrev_pair_buffer
  import fft_pkg::*;
#(
  parameter int N_POINTS = N_POINTS_DEF,
  parameter int DATA_W   = CPLX_W
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_W-1:0]              out_a,
  output logic [DATA_W-1:0]              out_b,
  output logic [$clog2(N_POINTS)-2:0]    out_pair_idx,
  output logic                           out_last
);

  localparam int LOG2N  = $clog2(N_POINTS);
  localparam int PAIR_W = LOG2N - 1;
  localparam logic [LOG2N-1:0]  LAST_SAMPLE = LOG2N'(N_POINTS - 1);
  localparam logic [PAIR_W-1:0] LAST_PAIR   = PAIR_W'(N_POINTS / 2 - 1);

  buf_state_e         r_state;
  logic [LOG2N-1:0]   r_wr_cnt;
  logic [PAIR_W-1:0]  r_rd_cnt;

  logic                 w_wr_en;
  logic                 w_last_accept;
  logic [PAIR_W-1:0]    w_next_rd;
  logic [IDX_MAX_W-1:0] w_idx_a;
  logic [IDX_MAX_W-1:0] w_idx_b;
  logic [IDX_MAX_W-1:0] w_rev_a;
  logic [IDX_MAX_W-1:0] w_rev_b;
  logic [LOG2N-1:0]     w_addr_a;
  logic [LOG2N-1:0]     w_addr_b;
  logic [DATA_W-1:0]    w_ram_a;
  logic [DATA_W-1:0]    w_ram_b;
  logic [DATA_W-1:0]    w_data_a;
  logic [DATA_W-1:0]    w_data_b;

  assign w_wr_en       = (r_state == ST_FILL) && in_valid;
  assign w_last_accept = w_wr_en && (r_wr_cnt == LAST_SAMPLE);

  // Outputs are registered, so the RAM is addressed with the pair that will be
  // shown after this edge: pair 0 while filling, rd_cnt+1 while draining.
  assign w_next_rd = (r_state == ST_DRAIN) ? (r_rd_cnt + PAIR_W'(1)) : '0;
  assign w_idx_a   = IDX_MAX_W'({w_next_rd, 1'b0});
  assign w_idx_b   = IDX_MAX_W'({w_next_rd, 1'b1});
  assign w_rev_a   = bitrev(w_idx_a, LOG2N);
  assign w_rev_b   = bitrev(w_idx_b, LOG2N);
  assign w_addr_a  = w_rev_a[LOG2N-1:0];
  assign w_addr_b  = w_rev_b[LOG2N-1:0];

  // Forward the sample being written this cycle in case pair 0 needs it.
  assign w_data_a = (w_wr_en && (w_addr_a == r_wr_cnt)) ? in_data : w_ram_a;
  assign w_data_b = (w_wr_en && (w_addr_b == r_wr_cnt)) ? in_data : w_ram_b;

  fft_frame_ram #(
    .DEPTH (N_POINTS),
    .AW    (LOG2N),
    .DW    (DATA_W)
  ) u_ram (
    .clk       (clk),
    .i_we      (w_wr_en),
    .i_waddr   (r_wr_cnt),
    .i_wdata   (in_data),
    .i_raddr_a (w_addr_a),
    .o_rdata_a (w_ram_a),
    .i_raddr_b (w_addr_b),
    .o_rdata_b (w_ram_b)
  );

  // Fill/drain FSM with registered handshake and pair outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FILL;
      r_wr_cnt     <= '0;
      r_rd_cnt     <= '0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_a        <= '0;
      out_b        <= '0;
      out_pair_idx <= '0;
      out_last     <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_last_accept) begin
            r_state      <= ST_DRAIN;
            r_wr_cnt     <= '0;
            r_rd_cnt     <= w_next_rd;
            in_ready     <= 1'b0;
            out_valid    <= 1'b1;
            out_a        <= w_data_a;
            out_b        <= w_data_b;
            out_pair_idx <= w_next_rd;
            out_last     <= (w_next_rd == LAST_PAIR);
          end else if (w_wr_en) begin
            r_wr_cnt <= r_wr_cnt + LOG2N'(1);
          end
        end
        ST_DRAIN: begin
          if (out_ready) begin
            if (r_rd_cnt == LAST_PAIR) begin
              r_state      <= ST_FILL;
              r_rd_cnt     <= '0;
              in_ready     <= 1'b1;
              out_valid    <= 1'b0;
              out_a        <= '0;
              out_b        <= '0;
              out_pair_idx <= '0;
              out_last     <= 1'b0;
            end else begin
              r_rd_cnt     <= w_next_rd;
              out_a        <= w_data_a;
              out_b        <= w_data_b;
              out_pair_idx <= w_next_rd;
              out_last     <= (w_next_rd == LAST_PAIR);
            end
          end
        end
        default: begin
          r_state      <= ST_FILL;
          r_wr_cnt     <= '0;
          r_rd_cnt     <= '0;
          in_ready     <= 1'b1;
          out_valid    <= 1'b0;
          out_a        <= '0;
          out_b        <= '0;
          out_pair_idx <= '0;
          out_last     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_bitrev_pair_buffer.sv
// Scoreboard bench for fft_bitrev_pair_buffer (N_POINTS=8): stimulus queues the
// hand-derived bit-reversed pairs, a negedge monitor checks every transfer.
module tb_fft_bitrev_pair_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_a;
  logic [7:0] out_b;
  logic [1:0] out_pair_idx;
  logic       out_last;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] idx;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  int         first_acc_cyc = 0;
  logic [7:0] frm [8];
  int         ord_a [4] = '{0, 2, 1, 3};
  int         ord_b [4] = '{4, 6, 5, 7};

  fft_bitrev_pair_buffer #(.N_POINTS(8), .DATA_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_a        (out_a),
    .out_b        (out_b),
    .out_pair_idx (out_pair_idx),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  task automatic exp_pair(input logic [7:0] a, input logic [7:0] b, input int k);
    exp_t e;
    e.a = a; e.b = b; e.idx = 2'(k); e.last = (k == 3);
    exp_q.push_back(e);
  endtask

  task automatic exp_frame();
    for (int k = 0; k < 4; k++) exp_pair(frm[ord_a[k]], frm[ord_b[k]], k);
  endtask

  task automatic push_sample(input logic [7:0] d);
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int gaps, input int start, input int n);
    for (int i = start; i < n; i++) begin
      if (gaps != 0 && i > start) begin @(posedge clk); #1; end
      if (i == 7) check("no_early_valid", out_valid, 0);
      push_sample(frm[i]);
      if (i == start) first_acc_cyc = cyc;
      if (i == 7) begin
        check("valid_1cyc_after_last", out_valid, 1);
        check("ready_low_in_drain", in_ready, 0);
      end
    end
  endtask

  task automatic wait_drained();
    int t = 0;
    while ((exp_q.size() != 0 || out_valid) && t < 200) begin @(negedge clk); t++; end
    check("drain_done", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor: compares each transferred pair, and zero outputs when idle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pair: got a=%0h b=%0h idx=%0d required none", out_a, out_b, out_pair_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("pair_a", out_a, e.a);
          check("pair_b", out_b, e.b);
          check("pair_idx", out_pair_idx, e.idx);
          check("pair_last", out_last, e.last);
        end
      end else if (!out_valid) begin
        check("idle_outputs_zero", {out_a, out_b, out_pair_idx, out_last}, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int t_a;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_a", out_a, 0);
    check("rst_out_b", out_b, 0);
    check("rst_idx", out_pair_idx, 0);
    check("rst_last", out_last, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Natural frame order, hand-derived pairs
    for (int i = 0; i < 8; i++) frm[i] = 8'h10 + 8'(i);
    exp_pair(8'h10, 8'h14, 0); exp_pair(8'h12, 8'h16, 1);
    exp_pair(8'h11, 8'h15, 2); exp_pair(8'h13, 8'h17, 3);
    send_frame(0, 0, 8);
    wait_drained();

    // Backpressure on pair 1 for three cycles
    exp_frame();
    send_frame(0, 0, 8);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_a", out_a, 8'h12);
      check("stall_b", out_b, 8'h16);
      check("stall_idx", out_pair_idx, 1);
    end
    out_ready = 1'b1;
    wait_drained();

    // Input gaps
    exp_pair(8'h10, 8'h14, 0); exp_pair(8'h12, 8'h16, 1);
    exp_pair(8'h11, 8'h15, 2); exp_pair(8'h13, 8'h17, 3);
    send_frame(1, 0, 8);
    wait_drained();

    // in_valid held high with 8'hFF through DRAIN; FF becomes sample 0 of next frame
    exp_frame();
    send_frame(0, 0, 8);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    t = 0;
    while (t < 50) begin
      @(negedge clk);
      if (in_ready) break;
      check("ready_low_hold", in_ready, 0);
      t++;
    end
    check("ready_back", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    frm = '{8'hFF, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37};
    exp_pair(8'hFF, 8'h34, 0); exp_pair(8'h32, 8'h36, 1);
    exp_pair(8'h31, 8'h35, 2); exp_pair(8'h33, 8'h37, 3);
    send_frame(0, 1, 8);
    wait_drained();

    // Reset mid-FILL after 5 samples
    for (int i = 0; i < 8; i++) frm[i] = 8'h30 + 8'(i);
    send_frame(0, 0, 5);
    rst_n = 1'b0;
    #1;
    check("rstfill_in_ready", in_ready, 1);
    check("rstfill_out_valid", out_valid, 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Reset mid-DRAIN after 2 pairs
    for (int i = 0; i < 8; i++) frm[i] = 8'h40 + 8'(i);
    exp_frame();
    send_frame(0, 0, 8);
    t = 0;
    while (t < 50) begin
      @(negedge clk); #1;
      if (exp_q.size() <= 2) break;
      t++;
    end
    check("two_pairs_popped", exp_q.size(), 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("rstdrain_out_valid", out_valid, 0);
    check("rstdrain_outs_zero", {out_a, out_b, out_pair_idx, out_last}, 0);
    check("rstdrain_in_ready", in_ready, 1);
    @(posedge clk); #1; rst_n = 1'b1;

    // Clean frame after reset
    for (int i = 0; i < 8; i++) frm[i] = 8'h20 + 8'(i);
    exp_pair(8'h20, 8'h24, 0); exp_pair(8'h22, 8'h26, 1);
    exp_pair(8'h21, 8'h25, 2); exp_pair(8'h23, 8'h27, 3);
    send_frame(0, 0, 8);
    wait_drained();

    // Back-to-back frames: 12-cycle period, FP4 special patterns bit-exact
    frm = '{8'h77, 8'hF0, 8'h08, 8'h00, 8'hF7, 8'h8F, 8'h7F, 8'h80};
    exp_pair(8'h77, 8'hF7, 0); exp_pair(8'h08, 8'h7F, 1);
    exp_pair(8'hF0, 8'h8F, 2); exp_pair(8'h00, 8'h80, 3);
    send_frame(0, 0, 8);
    t_a = first_acc_cyc;
    frm = '{8'h08, 8'h77, 8'hF0, 8'h88, 8'h0F, 8'hF8, 8'h70, 8'h07};
    exp_pair(8'h08, 8'h0F, 0); exp_pair(8'hF0, 8'h70, 1);
    exp_pair(8'h77, 8'hF8, 2); exp_pair(8'h88, 8'h07, 3);
    send_frame(0, 0, 8);
    check("frame_period", first_acc_cyc - t_a, 12);
    wait_drained();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
